// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard and branch-flush control for the 5-stage MIPS front end.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_rt_used,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_control,
  output logic              if_id_flush,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int REM_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

  typedef enum logic {
    RUN,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              haz;

  // Register $zero is never a real dependency, so a load into it never stalls.
  assign haz = id_ex_mem_read && (id_ex_rt != '0) &&
               ((id_ex_rt == if_id_rs) || (if_id_rt_used && (id_ex_rt == if_id_rt)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_control = 1'b1;
    if_id_flush   = 1'b0;
    state_d       = state_q;
    rem_d         = rem_q;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            id_ex_control = 1'b0;
            if_id_flush   = 1'b1;
          end else if (haz) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_control = 1'b0;
            if (LOAD_STALL > 1) begin
              state_d = HOLD;
              rem_d   = REM_W'(LOAD_STALL - 1);
            end
          end
        end
        HOLD: begin
          // A taken branch here aborts the remaining bubbles and flushes instead.
          if (ex_branch_taken) begin
            id_ex_control = 1'b0;
            if_id_flush   = 1'b1;
            rem_d         = '0;
            state_d       = RUN;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_control = 1'b0;
            rem_d         = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  assign stall_active = ~pc_write & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_active && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LOAD_STALL 1/3/4, one with a 2-bit counter)
// driven by shared directed and random stimulus, checked against a cycle-count reference model.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       mem_read;
  logic [4:0] ex_rt;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rt_used;
  logic       br;

  logic [2:0]  pcw_o, ifw_o, ctl_o, fl_o, sa_o;
  logic [15:0] sc0, sc2;
  logic [1:0]  sc1;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int     ls_tab [3] = '{1, 3, 4};
  int     cw_tab [3] = '{16, 2, 16};
  int     left   [3] = '{0, 0, 0};
  longint cnt    [3] = '{0, 0, 0};

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_rt_used(rt_used), .ex_branch_taken(br),
    .pc_write(pcw_o[0]), .if_id_write(ifw_o[0]), .id_ex_control(ctl_o[0]),
    .if_id_flush(fl_o[0]), .stall_active(sa_o[0]), .stall_cycles(sc0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(2)) u_ls3 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_rt_used(rt_used), .ex_branch_taken(br),
    .pc_write(pcw_o[1]), .if_id_write(ifw_o[1]), .id_ex_control(ctl_o[1]),
    .if_id_flush(fl_o[1]), .stall_active(sa_o[1]), .stall_cycles(sc1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(4), .CNT_W(16)) u_ls4 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_rt_used(rt_used), .ex_branch_taken(br),
    .pc_write(pcw_o[2]), .if_id_write(ifw_o[2]), .id_ex_control(ctl_o[2]),
    .if_id_flush(fl_o[2]), .stall_active(sa_o[2]), .stall_cycles(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] scOf(input int i);
    case (i)
      0:       return sc0;
      1:       return {14'b0, sc1};
      default: return sc2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int inst,
                             input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every instance against the model, then advance the model.
  task automatic applyStimulus(input logic rn, input logic m, input logic [4:0] r_ex,
                               input logic [4:0] r_s, input logic [4:0] r_t,
                               input logic u, input logic b);
    logic   h;
    logic   e_pc, e_ifw, e_ctl, e_fl, e_sa;
    int     nleft [3];
    longint ncnt  [3];
    rst_n = rn; mem_read = m; ex_rt = r_ex; rs = r_s; rt = r_t; rt_used = u; br = b;
    #2;
    h = m && (r_ex != 0) && ((r_ex == r_s) || (u && (r_ex == r_t)));
    for (int i = 0; i < 3; i++) begin
      e_pc = 1'b1; e_ifw = 1'b1; e_ctl = 1'b1; e_fl = 1'b0;
      nleft[i] = left[i];
      if (!rn) begin
        nleft[i] = 0;
      end else if (b) begin
        e_ctl = 1'b0; e_fl = 1'b1; nleft[i] = 0;
      end else if (left[i] > 0) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_ctl = 1'b0; nleft[i] = left[i] - 1;
      end else if (h) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_ctl = 1'b0; nleft[i] = ls_tab[i] - 1;
      end
      e_sa = !e_pc && rn;
      checkOutput("pc_write",      i, {15'b0, pcw_o[i]}, {15'b0, e_pc});
      checkOutput("if_id_write",   i, {15'b0, ifw_o[i]}, {15'b0, e_ifw});
      checkOutput("id_ex_control", i, {15'b0, ctl_o[i]}, {15'b0, e_ctl});
      checkOutput("if_id_flush",   i, {15'b0, fl_o[i]},  {15'b0, e_fl});
      checkOutput("stall_active",  i, {15'b0, sa_o[i]},  {15'b0, e_sa});
      checkOutput("stall_cycles",  i, scOf(i), PERF ? 16'(cnt[i]) : 16'h0);
      if (!rn) ncnt[i] = 0;
      else if (e_sa && cnt[i] < ((64'd1 << cw_tab[i]) - 1)) ncnt[i] = cnt[i] + 1;
      else ncnt[i] = cnt[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      left[i] = nleft[i];
      cnt[i]  = ncnt[i];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; ex_rt = '0; rs = '0; rt = '0; rt_used = 1'b0; br = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset with a live hazard on the inputs must still look like pass-through.
    applyStimulus(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    idle(1);

    $display("[TB] load-use on rs");
    applyStimulus(1'b1, 1'b1, 5'd9, 5'd9, 5'd4, 1'b0, 1'b0);
    idle(5);

    $display("[TB] load-use on rt, rt used then unused");
    applyStimulus(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0);
    idle(1);

    $display("[TB] load into $zero");
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(1);

    $display("[TB] hazard and branch together");
    applyStimulus(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
    idle(1);

    $display("[TB] reset during second hold cycle");
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    idle(2);

    $display("[TB] branch during hold");
    applyStimulus(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    idle(2);

    $display("[TB] counter saturation on 2-bit instance");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
      idle(4);
    end
    checkOutput("sat_cnt_w2", 1, {14'b0, sc1}, PERF ? 16'd3 : 16'd0);

    $display("[TB] random stimulus");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised load-use hazard and control-flush unit for the 5-stage MIPS pipeline, sitting between the IF/ID and ID/EX pipeline registers and driving the PC, IF/ID and ID/EX control-mux enables. It detects a load whose destination matches a source of the decoding instruction. It inserts a configurable number of bubbles, held by an internal counter. It also flushes wrong-path instructions on a taken branch resolved in EX, and never flags hazards on register $zero.

## Interface
Parameters:
- REG_AW, 5, register-address width
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal range 1..15
- CNT_W, 16, width of the stall-cycle counter (see Configuration)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  reset: synchronous, active-low
- id_ex_mem_read  input  1  instruction in ID/EX is a load
- id_ex_rt  input  REG_AW  load destination register
- if_id_rs  input  REG_AW  rs of the instruction in IF/ID
- if_id_rt  input  REG_AW  rt of the instruction in IF/ID
- if_id_rt_used  input  1  instruction in IF/ID reads rt (0 for I-type ALU/loads)
- ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register write enable
- id_ex_control  output  1  1 = pass decoded control to ID/EX; 0 = insert bubble (zero control)
- if_id_flush  output  1  clear IF/ID on next edge
- stall_active  output  1  high in every cycle the front end is held
- stall_cycles  output  CNT_W  saturating stall-cycle count (macro-dependent)

## Operation
- Hazard term: haz = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_rt_used & (id_ex_rt == if_id_rt))).
- FSM states: RUN, HOLD. Down-counter rem, width ceil(log2(LOAD_STALL)) bits, minimum 1.
- RUN, ex_branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_control=0. Stay in RUN. Branch has priority over haz.
- RUN, haz=1, no branch: pc_write=0, if_id_write=0, id_ex_control=0, if_id_flush=0. If LOAD_STALL=1, stay in RUN. Otherwise go to HOLD with rem=LOAD_STALL-1.
- RUN, neither: pass-through (pc_write=1, if_id_write=1, id_ex_control=1, if_id_flush=0).
- HOLD: same outputs as a stall, regardless of haz. rem decrements each cycle. When rem=1, next state is RUN.
- HOLD, ex_branch_taken=1 (not expected, since EX holds a bubble): branch outputs apply, rem is cleared, next state is RUN.
- stall_active = ~pc_write & rst_n.
- Outputs are combinational from state and current inputs. Only state, rem and stall_cycles are registered.

## Timing
- Reset (rst_n=0 at an edge): state=RUN, rem=0, stall_cycles=0.
- While rst_n=0, outputs are forced to pass-through: pc_write=1, if_id_write=1, id_ex_control=1, if_id_flush=0, stall_active=0.
- Reset mid-HOLD aborts the stall. RUN is in effect from the first cycle after the reset edge.
- Detection latency is 0 cycles: the first bubble is in the same cycle haz is seen.
- A hazard seen in cycle T holds the front end in cycles T..T+LOAD_STALL-1. RUN re-evaluates at T+LOAD_STALL. A stalled front end is exactly LOAD_STALL cycles.
- Back-to-back loads re-trigger only via fresh haz evaluation in RUN; no double counting within HOLD.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles increments by 1 on each clock edge where stall_active=1, saturates at 2^CNT_W-1, and clears on reset.
- HAZARD_PERF_CNT_EN undefined: the counter is not built and stall_cycles is tied to 0.

## Test plan
- LOAD_STALL=1. lw $t1 followed by add using $t1 as rs: in the detection cycle pc_write=0, if_id_write=0, id_ex_control=0; the next cycle is pass-through.
- LOAD_STALL=3. Load-use on rt with if_id_rt_used=1: exactly 3 stall cycles, stall_active high 3 cycles; with macro, stall_cycles=3. With if_id_rt_used=0, no stall.
- Load writing $0 matched by rs=0: no stall; outputs stay pass-through.
- haz=1 and ex_branch_taken=1 in the same cycle: if_id_flush=1, id_ex_control=0, pc_write=1, state stays RUN.
- LOAD_STALL=4. Assert rst_n=0 during the 2nd HOLD cycle: the next cycle is pass-through and stall_cycles=0.
- With macro and CNT_W=2: hold repeated stalls until stall_cycles reaches 3, and verify it stays at 3 (saturation).
